cache_controller: RTL and testbench
===================================

// Module: cache_controller
// PURPOSE
//  Control FSM for a 4-way set-associative, write-back, write-allocate data cache with LRU ages.
//  Sits between the CPU port, an external 4-bank tag/data array and a block-wide main-memory port.
//  Looks up the set, detects hit/miss, picks an LRU victim, writes back dirty victims,
//  refills and merges words, and writes the updated line back to the array.
// PARAMETERS
//  WORD_SIZE 32 CPU word/address width | BLOCK_OFFSET 4 word-offset bits (16 words/line)
//  SETS 128 sets | SETS_BITS 7 index bits | AGE_BITS 2 LRU age width | TAG_BITS 21 tag width
//  BLOCK_DATA_WIDTH 512 line width | DIRTY_BIT 1 | VALID_BIT 1 | BANK 4 ways
// PORTS
//  clk input 1 clock, all logic on rising edge
//  rst_n input 1 synchronous, active-low reset
//  cpu_req_addr input 32 {tag[31:11], index[10:4], word offset[3:0]}
//  cpu_req_datain input 32 write data | cpu_req_rw input 1 (1=write) | cpu_req_enable input 1 request strobe
//  cpu_res_dataout output 32 read word | cpu_res_ready output 1 one-cycle completion pulse
//  mem_req_addr output 32 line address {tag,index,4'b0} | mem_req_dataout output 512 write-back line
//  mem_req_datain input 512 refill line | mem_req_rw output 1 (1=write) | mem_req_enable output 1
//  mem_req_ready input 1 memory done (sampled while mem_req_enable=1)
//  cache_enable output 1 array access request | cache_rw output 1 (1=write) | cache_ready input 1 array done
//  candidate_1..4 input 537 each way of the set: {valid, dirty, age[1:0], tag[20:0], data[511:0]}
//  age_1..4 output 2 updated LRU ages written with the line
//  candidate_write output 537 line to store, same layout | bank_selector output 4 one-hot write way
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0.
//  Reset asserted mid-operation aborts to IDLE with all outputs 0 on the next edge.
//  IDLE: on cpu_req_enable, latch addr/data/rw -> LOOKUP. Requests outside IDLE are ignored.
//  LOOKUP: cache_enable=1, cache_rw=0. Wait for cache_ready, then sample candidates -> COMPARE.
//  COMPARE (1 cycle):
//   - Hit: way valid && tag match; lowest way wins ties.
//   - Victim on miss: lowest-numbered invalid way; else the way with the largest age (11 = oldest); lowest index on ties.
//   - Hit -> UPDATE.
//   - Miss with victim valid && dirty -> WRITEBACK.
//   - Otherwise -> ALLOCATE.
//  WRITEBACK: mem_req_enable=1, rw=1, addr={victim tag, index, 0}, dataout=victim data.
//   - On mem_req_ready -> ALLOCATE; mem_req_enable drops the cycle after.
//  ALLOCATE: mem_req_enable=1, rw=0, addr={req tag, index, 0}.
//   - On mem_req_ready, latch mem_req_datain -> UPDATE.
//  UPDATE: build the line for the target way (hit way or victim).
//   - Line = {1, dirty', 2'b00, tag, data'}.
//   - Write: data' = line with word[offset] (bits offset*32+:32) replaced by cpu_req_datain; dirty'=1.
//   - Read: data' unchanged; dirty' = old dirty on hit, 0 on refill.
//   - LRU: target age=0. Every other valid way with age < old target age increments. Invalid/refilled target counts as old age 3, all valid others +1 saturating. Other ages unchanged.
//   - Drive candidate_write, age_1..4, bank_selector=one-hot target, cache_enable=1, cache_rw=1.
//   - On cache_ready: cpu_res_dataout = data'[offset] for reads, cpu_res_ready=1 for one cycle -> IDLE.
//  bank_selector nonzero only in UPDATE. cpu_res_dataout holds until the next request.
//  No parity/error handling. Address bits beyond tag/index/offset: none (widths sum to 32).
// TESTING
//  Common setup: all ways valid+dirty unless stated; ways hold words 0xCAC8E000+i; memory returns 0xBAD00000+i.
//  Read hit: tags ABC/DEF/123/456, ages 10/01/00/11; read 0x0055E000
//   -> no mem access; cpu_res_dataout=0xCAC8E000; ages 00/10/01/11; bank 0001.
//  Read miss clean victim: ages 10/11/01/00, way2 clean; read 0x000A0000
//   -> one mem read 0x000A0000; victim way2, bank 0010; data 0xBAD00000; ages 11/00/10/01.
//  Write hit: way1 tag DEF; write 0xCAFEBABE to 0x006F7801
//   -> word1 of way1 = CAFEBABE; dirty=1; no mem access.
//  Write miss dirty victim: way1 tag 123, age 11, dirty; write 0x006F7801
//   -> mem write 0x00091800 then mem read 0x006F7800; line = {1,1,00,DEF, word1=CAFEBABE}; bank 0001.
//  Read miss with invalid ways: ways 3,4 invalid; read 0x006F7802
//   -> single mem read, victim way3 (bank 0100); cpu_res_dataout=0xBAD00002.
//  Reset asserted in ALLOCATE -> IDLE; all outputs 0 next cycle.

Source files
------------

// File: rtl/cache_controller.sv
// Control FSM for a 4-way set-associative, write-back, write-allocate data cache with LRU ages.
// Sequences array lookup, victim write-back, line refill and the merged line write-back to the array.
module cache_controller #(
    parameter int WORD_SIZE        = 32,
    parameter int BLOCK_OFFSET     = 4,
    parameter int SETS             = 128,
    parameter int SETS_BITS        = 7,
    parameter int AGE_BITS         = 2,
    parameter int TAG_BITS         = 21,
    parameter int BLOCK_DATA_WIDTH = 512,
    parameter int DIRTY_BIT        = 1,
    parameter int VALID_BIT        = 1,
    parameter int BANK             = 4,
    localparam int LINE_W = VALID_BIT + DIRTY_BIT + AGE_BITS + TAG_BITS + BLOCK_DATA_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [WORD_SIZE-1:0]        cpu_req_addr,
    input  logic [WORD_SIZE-1:0]        cpu_req_datain,
    input  logic                        cpu_req_rw,
    input  logic                        cpu_req_enable,
    output logic [WORD_SIZE-1:0]        cpu_res_dataout,
    output logic                        cpu_res_ready,
    output logic [WORD_SIZE-1:0]        mem_req_addr,
    output logic [BLOCK_DATA_WIDTH-1:0] mem_req_dataout,
    input  logic [BLOCK_DATA_WIDTH-1:0] mem_req_datain,
    output logic                        mem_req_rw,
    output logic                        mem_req_enable,
    input  logic                        mem_req_ready,
    output logic                        cache_enable,
    output logic                        cache_rw,
    input  logic                        cache_ready,
    input  logic [LINE_W-1:0]           candidate_1,
    input  logic [LINE_W-1:0]           candidate_2,
    input  logic [LINE_W-1:0]           candidate_3,
    input  logic [LINE_W-1:0]           candidate_4,
    output logic [AGE_BITS-1:0]         age_1,
    output logic [AGE_BITS-1:0]         age_2,
    output logic [AGE_BITS-1:0]         age_3,
    output logic [AGE_BITS-1:0]         age_4,
    output logic [LINE_W-1:0]           candidate_write,
    output logic [BANK-1:0]             bank_selector
);
    localparam int WAY_W     = $clog2(BANK);
    localparam int TAG_LO    = BLOCK_DATA_WIDTH;
    localparam int AGE_LO    = TAG_LO + TAG_BITS;
    localparam int DIRTY_POS = AGE_LO + AGE_BITS;
    localparam int VALID_POS = LINE_W - 1;

    if (SETS != (1 << SETS_BITS)) begin : g_bad_sets
        $error("SETS must equal 2**SETS_BITS");
    end

    typedef enum logic [2:0] {IDLE, LOOKUP, COMPARE, WRITEBACK, ALLOCATE, UPDATE} state_t;

    state_t                      state_q;
    logic [WORD_SIZE-1:0]        addr_q, wdata_q;
    logic                        rw_q, hit_q;
    logic [WAY_W-1:0]            target_q;
    logic [LINE_W-1:0]           cand_q [BANK];
    logic [BLOCK_DATA_WIDTH-1:0] refill_q;

    logic [WORD_SIZE-1:0]        cpu_dout_q, mem_addr_q;
    logic                        cpu_ready_q, mem_rw_q, mem_en_q, cache_en_q, cache_rw_q;
    logic [BLOCK_DATA_WIDTH-1:0] mem_dout_q;
    logic [AGE_BITS-1:0]         age_q [BANK];
    logic [LINE_W-1:0]           cand_wr_q;
    logic [BANK-1:0]             bank_q;

    logic [LINE_W-1:0]           cand_in [BANK];
    logic [TAG_BITS-1:0]         req_tag;
    logic [SETS_BITS-1:0]        req_idx;
    logic [BLOCK_OFFSET-1:0]     req_off;

    assign cand_in[0] = candidate_1;
    assign cand_in[1] = candidate_2;
    assign cand_in[2] = candidate_3;
    assign cand_in[3] = candidate_4;

    assign req_tag = addr_q[WORD_SIZE-1 -: TAG_BITS];
    assign req_idx = addr_q[BLOCK_OFFSET +: SETS_BITS];
    assign req_off = addr_q[BLOCK_OFFSET-1:0];

    assign cpu_res_dataout = cpu_dout_q;
    assign cpu_res_ready   = cpu_ready_q;
    assign mem_req_addr    = mem_addr_q;
    assign mem_req_dataout = mem_dout_q;
    assign mem_req_rw      = mem_rw_q;
    assign mem_req_enable  = mem_en_q;
    assign cache_enable    = cache_en_q;
    assign cache_rw        = cache_rw_q;
    assign age_1           = age_q[0];
    assign age_2           = age_q[1];
    assign age_3           = age_q[2];
    assign age_4           = age_q[3];
    assign candidate_write = cand_wr_q;
    assign bank_selector   = bank_q;

    // Hit detection and victim choice over the sampled set; lowest way wins every tie.
    logic                hit_d, inv_found;
    logic [WAY_W-1:0]    hit_way_d, victim_d;
    logic [AGE_BITS-1:0] victim_age;

    always_comb begin
        hit_d      = 1'b0;
        hit_way_d  = '0;
        inv_found  = 1'b0;
        victim_d   = '0;
        victim_age = '0;
        for (int i = 0; i < BANK; i++) begin
            if (!hit_d && cand_q[i][VALID_POS] && cand_q[i][TAG_LO +: TAG_BITS] == req_tag) begin
                hit_d     = 1'b1;
                hit_way_d = WAY_W'(i);
            end
            if (!inv_found && !cand_q[i][VALID_POS]) begin
                inv_found = 1'b1;
                victim_d  = WAY_W'(i);
            end
        end
        if (!inv_found) begin
            victim_age = cand_q[0][AGE_LO +: AGE_BITS];
            for (int i = 1; i < BANK; i++) begin
                if (cand_q[i][AGE_LO +: AGE_BITS] > victim_age) begin
                    victim_age = cand_q[i][AGE_LO +: AGE_BITS];
                    victim_d   = WAY_W'(i);
                end
            end
        end
    end

    // Merged line and LRU ages; a refilled target behaves as if it were the oldest way.
    logic [LINE_W-1:0]           tgt_line, line_d;
    logic [BLOCK_DATA_WIDTH-1:0] data_d;
    logic [AGE_BITS-1:0]         old_age, ages_d [BANK];
    logic [WORD_SIZE-1:0]        rdword_d;
    logic                        dirty_d;

    always_comb begin
        tgt_line = cand_q[target_q];
        old_age  = hit_q ? tgt_line[AGE_LO +: AGE_BITS] : '1;
        data_d   = hit_q ? tgt_line[BLOCK_DATA_WIDTH-1:0] : refill_q;
        if (rw_q) begin
            data_d[int'(req_off)*WORD_SIZE +: WORD_SIZE] = wdata_q;
        end
        dirty_d  = rw_q | (hit_q & tgt_line[DIRTY_POS]);
        line_d   = {1'b1, dirty_d, {AGE_BITS{1'b0}}, req_tag, data_d};
        rdword_d = data_d[int'(req_off)*WORD_SIZE +: WORD_SIZE];
        for (int i = 0; i < BANK; i++) begin
            ages_d[i] = cand_q[i][AGE_LO +: AGE_BITS];
            if (WAY_W'(i) == target_q) begin
                ages_d[i] = '0;
            end else if (cand_q[i][VALID_POS] && ages_d[i] < old_age) begin
                ages_d[i] = ages_d[i] + AGE_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cpu_dout_q  <= '0;
            cpu_ready_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_dout_q  <= '0;
            mem_rw_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            cache_en_q  <= 1'b0;
            cache_rw_q  <= 1'b0;
            cand_wr_q   <= '0;
            bank_q      <= '0;
            for (int i = 0; i < BANK; i++) age_q[i] <= '0;
        end else begin
            cpu_ready_q <= 1'b0;
            case (state_q)
                IDLE: if (cpu_req_enable) begin
                    addr_q     <= cpu_req_addr;
                    wdata_q    <= cpu_req_datain;
                    rw_q       <= cpu_req_rw;
                    cache_en_q <= 1'b1;
                    cache_rw_q <= 1'b0;
                    state_q    <= LOOKUP;
                end
                LOOKUP: if (cache_ready) begin
                    for (int i = 0; i < BANK; i++) cand_q[i] <= cand_in[i];
                    cache_en_q <= 1'b0;
                    state_q    <= COMPARE;
                end
                COMPARE: begin
                    hit_q <= hit_d;
                    if (hit_d) begin
                        target_q <= hit_way_d;
                        state_q  <= UPDATE;
                    end else begin
                        target_q <= victim_d;
                        if (cand_q[victim_d][VALID_POS] && cand_q[victim_d][DIRTY_POS]) begin
                            mem_en_q   <= 1'b1;
                            mem_rw_q   <= 1'b1;
                            mem_addr_q <= {cand_q[victim_d][TAG_LO +: TAG_BITS], req_idx, {BLOCK_OFFSET{1'b0}}};
                            mem_dout_q <= cand_q[victim_d][BLOCK_DATA_WIDTH-1:0];
                            state_q    <= WRITEBACK;
                        end else begin
                            state_q    <= ALLOCATE;
                        end
                    end
                end
                WRITEBACK: if (mem_req_ready) begin
                    mem_en_q <= 1'b0;
                    state_q  <= ALLOCATE;
                end
                // Enable is re-raised one cycle after a write-back so the two transfers stay distinct.
                ALLOCATE: if (!mem_en_q) begin
                    mem_en_q   <= 1'b1;
                    mem_rw_q   <= 1'b0;
                    mem_addr_q <= {req_tag, req_idx, {BLOCK_OFFSET{1'b0}}};
                end else if (mem_req_ready) begin
                    refill_q <= mem_req_datain;
                    mem_en_q <= 1'b0;
                    state_q  <= UPDATE;
                end
                UPDATE: if (!cache_en_q) begin
                    cand_wr_q  <= line_d;
                    for (int i = 0; i < BANK; i++) age_q[i] <= ages_d[i];
                    bank_q     <= BANK'(1) << target_q;
                    cache_en_q <= 1'b1;
                    cache_rw_q <= 1'b1;
                end else if (cache_ready) begin
                    if (!rw_q) cpu_dout_q <= rdword_d;
                    cpu_ready_q <= 1'b1;
                    cache_en_q  <= 1'b0;
                    cache_rw_q  <= 1'b0;
                    bank_q      <= '0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: behavioural set model predicts array writes, memory
// transfers and read data; array and memory responders run as separate processes.
module tb_cache_controller;
    typedef logic [536:0] line_t;
    typedef struct {
        bit          rd;
        logic [31:0] rdata;
        logic [3:0]  bank;
        line_t       line;
        logic [7:0]  ages;
    } exp_t;
    typedef struct {
        bit           rw;
        logic [31:0]  addr;
        logic [511:0] data;
    } mtx_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  cpu_req_addr, cpu_req_datain;
    logic         cpu_req_rw, cpu_req_enable;
    logic [31:0]  cpu_res_dataout;
    logic         cpu_res_ready;
    logic [31:0]  mem_req_addr;
    logic [511:0] mem_req_dataout;
    logic [511:0] mem_req_datain = '0;
    logic         mem_req_rw, mem_req_enable;
    logic         mem_req_ready = 1'b0;
    logic         cache_enable, cache_rw;
    logic         cache_ready = 1'b0;
    line_t        candidate_1, candidate_2, candidate_3, candidate_4, candidate_write;
    logic [1:0]   age_1, age_2, age_3, age_4;
    logic [3:0]   bank_selector;

    line_t        arr     [128][4];
    line_t        ref_arr [128][4];
    logic [6:0]   cur_idx = '0;
    exp_t         exp_q[$];
    mtx_t         mexp_q[$];
    int           nchk = 0, nerr = 0;
    int           mem_lat = 2, cache_lat = 1;
    logic [31:0]  mem_salt = '0;
    bit           obs_seen = 0;
    logic [3:0]   obs_bank;
    line_t        obs_line;
    logic [7:0]   obs_ages;

    always #5 clk = ~clk;

    assign candidate_1 = arr[cur_idx][0];
    assign candidate_2 = arr[cur_idx][1];
    assign candidate_3 = arr[cur_idx][2];
    assign candidate_4 = arr[cur_idx][3];

    cache_controller dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_addr(cpu_req_addr), .cpu_req_datain(cpu_req_datain),
        .cpu_req_rw(cpu_req_rw), .cpu_req_enable(cpu_req_enable),
        .cpu_res_dataout(cpu_res_dataout), .cpu_res_ready(cpu_res_ready),
        .mem_req_addr(mem_req_addr), .mem_req_dataout(mem_req_dataout),
        .mem_req_datain(mem_req_datain), .mem_req_rw(mem_req_rw),
        .mem_req_enable(mem_req_enable), .mem_req_ready(mem_req_ready),
        .cache_enable(cache_enable), .cache_rw(cache_rw), .cache_ready(cache_ready),
        .candidate_1(candidate_1), .candidate_2(candidate_2),
        .candidate_3(candidate_3), .candidate_4(candidate_4),
        .age_1(age_1), .age_2(age_2), .age_3(age_3), .age_4(age_4),
        .candidate_write(candidate_write), .bank_selector(bank_selector)
    );

    task automatic chk(input string name, input logic [575:0] got, input logic [575:0] want);
        nchk++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic [511:0] mline(input logic [31:0] salt);
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = 32'hBAD00000 + 32'(i) + salt;
        return d;
    endfunction

    // Reference: hit search, victim choice, transfers and LRU ages from the plain cache rules.
    task automatic model(input logic [31:0] addr, input logic rw, input logic [31:0] wd,
                         output exp_t e, output line_t ns [4]);
        logic [20:0]  tag;
        logic [6:0]   idx;
        int           off, way;
        bit           hit;
        logic [1:0]   old, a;
        logic [511:0] data;
        logic         dirty;
        mtx_t         m;
        tag = addr[31:11];
        idx = addr[10:4];
        off = int'(addr[3:0]);
        way = -1;
        for (int w = 0; w < 4; w++)
            if (way < 0 && ref_arr[idx][w][536] && ref_arr[idx][w][532:512] == tag) way = w;
        hit = (way >= 0);
        if (hit) begin
            data = ref_arr[idx][way][511:0];
            old  = ref_arr[idx][way][534:533];
        end else begin
            for (int w = 0; w < 4; w++)
                if (way < 0 && !ref_arr[idx][w][536]) way = w;
            if (way < 0) begin
                way = 0;
                for (int w = 1; w < 4; w++)
                    if (ref_arr[idx][w][534:533] > ref_arr[idx][way][534:533]) way = w;
            end
            if (ref_arr[idx][way][536] && ref_arr[idx][way][535]) begin
                m.rw   = 1;
                m.addr = {ref_arr[idx][way][532:512], idx, 4'h0};
                m.data = ref_arr[idx][way][511:0];
                mexp_q.push_back(m);
            end
            m.rw   = 0;
            m.addr = {tag, idx, 4'h0};
            m.data = '0;
            mexp_q.push_back(m);
            data = mline(mem_salt);
            old  = 2'd3;
        end
        if (rw) data[off*32 +: 32] = wd;
        dirty = rw || (hit && ref_arr[idx][way][535]);
        for (int w = 0; w < 4; w++) begin
            a = ref_arr[idx][w][534:533];
            if (w == way) a = 2'd0;
            else if (ref_arr[idx][w][536] && a < old) a = a + 2'd1;
            ns[w] = ref_arr[idx][w];
            ns[w][534:533] = a;
            e.ages[w*2 +: 2] = a;
        end
        e.line  = {1'b1, dirty, 2'b00, tag, data};
        ns[way] = e.line;
        e.bank  = 4'b0001 << way;
        e.rd    = !rw;
        e.rdata = data[off*32 +: 32];
    endtask

    // Tag/data array responder: answers cache_enable after cache_lat cycles and stores writes.
    int ccnt = 0;
    always @(negedge clk) begin
        if (cache_enable && !cache_ready) begin
            ccnt++;
            if (ccnt >= cache_lat) begin
                cache_ready = 1'b1;
                ccnt = 0;
                if (cache_rw) begin
                    obs_seen = 1;
                    obs_bank = bank_selector;
                    obs_line = candidate_write;
                    obs_ages = {age_4, age_3, age_2, age_1};
                    for (int w = 0; w < 4; w++) if (bank_selector[w]) arr[cur_idx][w] = candidate_write;
                    arr[cur_idx][0][534:533] = age_1;
                    arr[cur_idx][1][534:533] = age_2;
                    arr[cur_idx][2][534:533] = age_3;
                    arr[cur_idx][3][534:533] = age_4;
                end
            end
        end else begin
            cache_ready = 1'b0;
            ccnt = 0;
        end
    end

    // Main memory responder; each completed transfer is checked against the expected sequence.
    int mcnt = 0;
    always @(negedge clk) begin
        mtx_t m;
        if (mem_req_enable && !mem_req_ready) begin
            mcnt++;
            if (mcnt >= mem_lat) begin
                mem_req_ready  = 1'b1;
                mem_req_datain = mline(mem_salt);
                mcnt = 0;
                if (mexp_q.size() == 0) begin
                    nchk++;
                    nerr++;
                    $display("FAIL mem_unexpected: got rw=%0b addr=%h expected no transfer", mem_req_rw, mem_req_addr);
                end else begin
                    m = mexp_q.pop_front();
                    chk("mem_rw", 576'(mem_req_rw), 576'(m.rw));
                    chk("mem_addr", 576'(mem_req_addr), 576'(m.addr));
                    if (m.rw) chk("mem_wb_data", 576'(mem_req_dataout), 576'(m.data));
                end
            end
        end else begin
            mem_req_ready = 1'b0;
            mcnt = 0;
        end
    end

    // Completion monitor.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && cpu_res_ready) begin
            if (exp_q.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL cpu_unexpected_ready: got ready=1 expected no completion");
            end else begin
                e = exp_q.pop_front();
                chk("array_write_seen", 576'(obs_seen), 576'(1));
                chk("bank_selector", 576'(obs_bank), 576'(e.bank));
                chk("line_written", 576'(obs_line), 576'(e.line));
                chk("ages_written", 576'(obs_ages), 576'(e.ages));
                chk("mem_transfers_left", 576'(mexp_q.size()), 576'(0));
                if (e.rd) chk("read_data", 576'(cpu_res_dataout), 576'(e.rdata));
            end
            obs_seen = 0;
        end
    end

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    endtask

    task automatic do_req(input logic [31:0] addr, input logic rw, input logic [31:0] wd);
        exp_t  e;
        line_t ns [4];
        bit    done;
        cur_idx = addr[10:4];
        model(addr, rw, wd, e, ns);
        exp_q.push_back(e);
        cpu_req_addr   = addr;
        cpu_req_rw     = rw;
        cpu_req_datain = wd;
        cpu_req_enable = 1'b1;
        @(negedge clk);
        cpu_req_enable = 1'b0;
        done = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (cpu_res_ready) begin
                done = 1;
                cpu_req_enable = 1'b0;
            end else if ($urandom_range(3) == 0) begin
                cpu_req_enable = 1'b1;
                cpu_req_addr   = $urandom;
                cpu_req_rw     = 1'($urandom_range(1));
                cpu_req_datain = $urandom;
            end else begin
                cpu_req_enable = 1'b0;
            end
        end
        cpu_req_enable = 1'b0;
        if (!done) begin
            nchk++;
            nerr++;
            $display("FAIL request_timeout: got no cpu_res_ready for addr %h expected completion", addr);
            finish_run();
        end
        for (int w = 0; w < 4; w++) ref_arr[cur_idx][w] = ns[w];
        @(negedge clk);
    endtask

    task automatic put(input int w, input bit v, input bit d, input logic [1:0] a, input logic [20:0] t);
        line_t l;
        l[536] = v;
        l[535] = d;
        l[534:533] = a;
        l[532:512] = t;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = 32'hCAC8E000 + 32'(i);
        arr[0][w] = l;
        ref_arr[0][w] = l;
    endtask

    initial begin
        #3_000_000;
        nchk++;
        nerr++;
        $display("FAIL global_watchdog: got no end of run expected completion");
        finish_run();
    end

    initial begin
        bit seen;
        for (int s = 0; s < 128; s++)
            for (int w = 0; w < 4; w++) begin
                arr[s][w] = '0;
                ref_arr[s][w] = '0;
            end
        rst_n = 1'b0;
        cpu_req_addr = '0;
        cpu_req_datain = '0;
        cpu_req_rw = 1'b0;
        cpu_req_enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl_outputs", 576'({cpu_res_dataout, cpu_res_ready, mem_req_addr, mem_req_rw,
             mem_req_enable, cache_enable, cache_rw, age_1, age_2, age_3, age_4, bank_selector}), 576'(0));
        chk("reset_candidate_write", 576'(candidate_write), 576'(0));
        chk("reset_mem_dataout", 576'(mem_req_dataout), 576'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Read hit on way1.
        put(0, 1, 1, 2'd2, 21'hABC); put(1, 1, 1, 2'd1, 21'hDEF);
        put(2, 1, 1, 2'd0, 21'h123); put(3, 1, 1, 2'd3, 21'h456);
        do_req(32'h0055E000, 1'b0, 32'h0);
        // Read miss, clean oldest victim way2.
        put(0, 1, 1, 2'd2, 21'hABC); put(1, 1, 0, 2'd3, 21'hDEF);
        put(2, 1, 1, 2'd1, 21'h123); put(3, 1, 1, 2'd0, 21'h456);
        do_req(32'h000A0000, 1'b0, 32'h0);
        // Write hit on way1.
        put(0, 1, 1, 2'd0, 21'hDEF); put(1, 1, 1, 2'd1, 21'hABC);
        put(2, 1, 1, 2'd2, 21'h123); put(3, 1, 1, 2'd3, 21'h456);
        do_req(32'h006F7801, 1'b1, 32'hCAFEBABE);
        // Write miss with dirty victim way1.
        put(0, 1, 1, 2'd3, 21'h123); put(1, 1, 1, 2'd0, 21'hABC);
        put(2, 1, 1, 2'd1, 21'h456); put(3, 1, 1, 2'd2, 21'h789);
        do_req(32'h006F7801, 1'b1, 32'hCAFEBABE);
        // Read miss with ways 3 and 4 invalid.
        put(0, 1, 1, 2'd1, 21'hABC); put(1, 1, 1, 2'd0, 21'h123);
        put(2, 0, 0, 2'd0, 21'h0);   put(3, 0, 0, 2'd0, 21'h0);
        do_req(32'h006F7802, 1'b0, 32'h0);

        // Reset while the refill read is outstanding.
        put(0, 1, 0, 2'd0, 21'h111); put(1, 1, 0, 2'd1, 21'h222);
        put(2, 1, 0, 2'd2, 21'h333); put(3, 1, 0, 2'd3, 21'h444);
        mem_lat = 6;
        cur_idx = 7'd0;
        cpu_req_addr = 32'h00AAA000;
        cpu_req_rw = 1'b0;
        cpu_req_enable = 1'b1;
        @(negedge clk);
        cpu_req_enable = 1'b0;
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (mem_req_enable && !mem_req_rw) seen = 1;
        end
        chk("reached_allocate", 576'(seen), 576'(1));
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_ctrl_outputs", 576'({cpu_res_dataout, cpu_res_ready, mem_req_addr, mem_req_rw,
             mem_req_enable, cache_enable, cache_rw, age_1, age_2, age_3, age_4, bank_selector}), 576'(0));
        chk("abort_candidate_write", 576'(candidate_write), 576'(0));
        chk("abort_mem_dataout", 576'(mem_req_dataout), 576'(0));
        rst_n = 1'b1;
        exp_q.delete();
        mexp_q.delete();
        obs_seen = 0;
        mem_lat = 2;
        @(negedge clk);
        do_req(32'h00AAA004, 1'b0, 32'h0);

        // Randomised traffic over a few sets and a small tag pool.
        for (int r = 0; r < 150; r++) begin
            logic [31:0] a;
            a = {21'($urandom_range(5)), 7'(1 + $urandom_range(3)), 4'($urandom_range(15))};
            mem_salt  = $urandom;
            mem_lat   = 1 + $urandom_range(3);
            cache_lat = 1 + $urandom_range(2);
            do_req(a, 1'($urandom_range(1)), $urandom);
        end

        repeat (3) @(negedge clk);
        finish_run();
    end
endmodule
